// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it
// against an internal word array after a fixed latency and holds the
// response until the requester takes it.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        MEM_req_valid,
  output logic        MEM_req_ready,
  input  logic        MEM_req_write,
  input  logic [31:0] MEM_req_address,
  input  logic [1:0]  MEM_req_length,
  input  logic        MEM_req_signed,
  input  logic [31:0] MEM_req_wdata,
  output logic        MEM_resp_valid,
  input  logic        MEM_resp_ready,
  output logic [31:0] MEM_resp_rdata,
  output logic        MEM_resp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, signed_q;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    len_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic [31:0]   mem [0:DEPTH_WORDS-1];
  logic [31:0]   rd_word_q;

  logic          accept, commit;
  logic [AW-1:0] req_idx, wr_idx;
  logic [31:0]   off_q;
  logic          access_err;
  logic [31:0]   load_val;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;

  assign accept  = (state_q == IDLE) && MEM_req_valid;
  assign commit  = (state_q == BUSY) && (cnt_q == '0);
  assign req_idx = AW'((MEM_req_address - BASE_ADDRESS) >> 2);
  assign off_q   = addr_q - BASE_ADDRESS;
  assign wr_idx  = AW'(off_q >> 2);

  // Fault detection on the latched request: alignment, range, malformed load.
  always_comb begin
    access_err = 1'b0;
    if (len_q == LEN_HALF && addr_q[0])            access_err = 1'b1;
    if (len_q == LEN_WORD && addr_q[1:0] != 2'b00) access_err = 1'b1;
    if ({1'b0, off_q} >= LIMIT_BYTES)              access_err = 1'b1;
    if (!write_q && len_q == LEN_NONE)             access_err = 1'b1;
  end

  // Lane selection and sign/zero extension of the word read at acceptance.
  always_comb begin
    sel_byte = 8'h00;
    case (off_q[1:0])
      2'd0:    sel_byte = rd_word_q[7:0];
      2'd1:    sel_byte = rd_word_q[15:8];
      2'd2:    sel_byte = rd_word_q[23:16];
      default: sel_byte = rd_word_q[31:24];
    endcase
    sel_half = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    load_val = 32'h0;
    case (len_q)
      LEN_BYTE: load_val = signed_q ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      LEN_HALF: load_val = signed_q ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
      LEN_WORD: load_val = rd_word_q;
      default:  load_val = 32'h0;
    endcase
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    case (len_q)
      LEN_BYTE: begin
        wr_be   = 4'b0001 << off_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      LEN_HALF: begin
        wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      LEN_WORD: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = wdata_q;
      end
    endcase
  end

  // Stores only commit on the final BUSY edge, so a reset before then drops them.
  assign wr_en = commit && write_q && !access_err && (len_q != LEN_NONE);

  // Registered read: the addressed word is captured when the request is
  // accepted; nothing else can write the array before this access commits.
  always_ff @(posedge SYS_clk) begin
    if (accept) rd_word_q <= mem[req_idx];
  end

  // Byte-enabled array write; the array is deliberately not reset.
  always_ff @(posedge SYS_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: latency countdown, access on the final BUSY edge, response hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (MEM_req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RESP;
          error_d = access_err;
          rdata_d = (access_err || write_q) ? 32'h0 : load_val;
        end
      end
      RESP: begin
        if (MEM_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, response and request-capture registers.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      len_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q  <= MEM_req_write;
        signed_q <= MEM_req_signed;
        addr_q   <= MEM_req_address;
        wdata_q  <= MEM_req_wdata;
        len_q    <= MEM_req_length;
      end
    end
  end

  assign MEM_req_ready  = (state_q == IDLE);
  assign MEM_resp_valid = (state_q == RESP);
  assign MEM_resp_rdata = rdata_q;
  assign MEM_resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests with literal expectations,
// plus a byte-level reference model compared every cycle (LATENCY=2 instance).
// A second instance (LATENCY=3) covers reset during an in-flight store.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst2_n = 1'b1, rst3_n = 1'b1;
  logic        v2 = 1'b0, v3 = 1'b0, rr2 = 1'b0, rr3 = 1'b0;
  logic        req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_len = 2'b00;
  logic        rdy2, rdy3, val2, val3, err2, err3;
  logic [31:0] rd2, rd3;

  int checks = 0;
  int failures = 0;
  logic sel = 1'b0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDRESS(32'h0)) dut (
    .SYS_clk(clk), .SYS_reset(rst2_n),
    .MEM_req_valid(v2), .MEM_req_ready(rdy2), .MEM_req_write(req_write),
    .MEM_req_address(req_addr), .MEM_req_length(req_len), .MEM_req_signed(req_signed),
    .MEM_req_wdata(req_wdata), .MEM_resp_valid(val2), .MEM_resp_ready(rr2),
    .MEM_resp_rdata(rd2), .MEM_resp_error(err2));

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDRESS(32'h0)) dut3 (
    .SYS_clk(clk), .SYS_reset(rst3_n),
    .MEM_req_valid(v3), .MEM_req_ready(rdy3), .MEM_req_write(req_write),
    .MEM_req_address(req_addr), .MEM_req_length(req_len), .MEM_req_signed(req_signed),
    .MEM_req_wdata(req_wdata), .MEM_resp_valid(val3), .MEM_resp_ready(rr3),
    .MEM_resp_rdata(rd3), .MEM_resp_error(err3));

  wire        cur_ready = sel ? rdy3 : rdy2;
  wire        cur_valid = sel ? val3 : val2;
  wire [31:0] cur_rdata = sel ? rd3 : rd2;
  wire        cur_error = sel ? err3 : err2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: memory as bytes, response computed in full at acceptance.
  logic [7:0]  mb [0:4095];
  logic        m_pending = 1'b0;
  int          m_age = 0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_error = 1'b0;

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (m_age >= 2 && rr2) m_pending = 1'b0;
      else if (m_age < 2) m_age++;
    end else if (v2) begin
      logic [31:0] off;
      int n;
      logic [31:0] val;
      off = req_addr;
      n = (req_len == 2'b01) ? 1 : (req_len == 2'b10) ? 2 : (req_len == 2'b11) ? 4 : 0;
      m_error = ((req_len == 2'b10) && (req_addr % 2 != 0)) ||
                ((req_len == 2'b11) && (req_addr % 4 != 0)) ||
                (off >= 32'd4096) || (!req_write && n == 0);
      m_rdata = 32'h0;
      if (!m_error) begin
        if (req_write) begin
          for (int i = 0; i < n; i++) mb[off + i] = req_wdata[8*i +: 8];
        end else begin
          val = 32'h0;
          for (int i = 0; i < n; i++) val = val | (32'(mb[off + i]) << (8*i));
          if (req_signed && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
          m_rdata = val;
        end
      end
      m_pending = 1'b1;
      m_age = 0;
    end
  end

  // Per-cycle comparison of the LATENCY=2 instance against the model.
  always @(negedge clk) begin
    if (cmp_en && rst2_n) begin
      chk("model_req_ready", {31'b0, rdy2}, {31'b0, !m_pending});
      chk("model_resp_valid", {31'b0, val2}, {31'b0, m_pending && m_age >= 2});
      if (m_pending && m_age >= 2) begin
        chk("model_rdata", rd2, m_rdata);
        chk("model_error", {31'b0, err2}, {31'b0, m_error});
      end
    end
  end

  task automatic do_req(input logic s_i, input logic w, input logic [31:0] a,
                        input logic [1:0] l, input logic sg, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int hold,
                        input string nm);
    int lat;
    int g;
    int exp_lat;
    exp_lat = s_i ? 3 : 2;
    @(negedge clk);
    sel = s_i;
    req_write = w; req_addr = a; req_len = l; req_signed = sg; req_wdata = wd;
    if (s_i) v3 = 1'b1; else v2 = 1'b1;
    g = 0;
    while (!cur_ready && g < 20) begin @(negedge clk); g++; end
    chk({nm, "_ready"}, {31'b0, cur_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0; v3 = 1'b0;
    lat = 0;
    while (!cur_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rdata"}, cur_rdata, er);
    chk({nm, "_error"}, {31'b0, cur_error}, {31'b0, ee});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, {31'b0, cur_valid}, 32'd1);
      chk({nm, "_hold_ready"}, {31'b0, cur_ready}, 32'd0);
      chk({nm, "_hold_rdata"}, cur_rdata, er);
      chk({nm, "_hold_error"}, {31'b0, cur_error}, {31'b0, ee});
    end
    if (s_i) rr3 = 1'b1; else rr2 = 1'b1;
    @(negedge clk);
    rr2 = 1'b0; rr3 = 1'b0;
    chk({nm, "_idle_ready"}, {31'b0, cur_ready}, 32'd1);
    chk({nm, "_idle_valid"}, {31'b0, cur_valid}, 32'd0);
    $display("txn %s sel=%0d w=%0d addr=%h len=%0d rdata=%h err=%0d lat=%0d",
             nm, s_i, w, a, l, cur_rdata, cur_error, lat);
  endtask

  initial begin
    #1;
    rst2_n = 1'b0; rst3_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, rdy2}, 32'd1);
    chk("rst_resp_valid", {31'b0, val2}, 32'd0);
    chk("rst_rdata", rd2, 32'h0);
    chk("rst_error", {31'b0, err2}, 32'd0);
    repeat (2) @(negedge clk);
    rst2_n = 1'b1; rst3_n = 1'b1;
    cmp_en = 1'b1;

    do_req(0, 1, 32'h10,  2'b11, 0, 32'hDEADBEEF, 32'h0,        0, 0, "sw_10");
    do_req(0, 0, 32'h10,  2'b11, 0, 32'h0,        32'hDEADBEEF, 0, 0, "lw_10");
    do_req(0, 0, 32'h13,  2'b01, 1, 32'h0,        32'hFFFFFFDE, 0, 0, "lb_13");
    do_req(0, 0, 32'h13,  2'b01, 0, 32'h0,        32'h000000DE, 0, 0, "lbu_13");
    do_req(0, 0, 32'h10,  2'b10, 1, 32'h0,        32'hFFFFBEEF, 0, 0, "lh_10");
    do_req(0, 0, 32'h12,  2'b10, 0, 32'h0,        32'h0000DEAD, 0, 0, "lhu_12");
    do_req(0, 1, 32'h11,  2'b01, 0, 32'hAAAAAA55, 32'h0,        0, 0, "sb_11");
    do_req(0, 0, 32'h10,  2'b11, 0, 32'h0,        32'hDEAD55EF, 0, 0, "lw_after_sb");
    do_req(0, 1, 32'h12,  2'b10, 0, 32'hFFFF1234, 32'h0,        0, 0, "sh_12");
    do_req(0, 0, 32'h10,  2'b11, 0, 32'h0,        32'h123455EF, 0, 0, "lw_after_sh");
    do_req(0, 0, 32'h12,  2'b11, 0, 32'h0,        32'h0,        1, 0, "lw_misalign");
    do_req(0, 0, 32'h11,  2'b10, 1, 32'h0,        32'h0,        1, 0, "lh_misalign");
    do_req(0, 1, 32'h0,   2'b11, 0, 32'hCAFEF00D, 32'h0,        0, 0, "sw_0");
    do_req(0, 1, 32'h1000, 2'b11, 0, 32'h12345678, 32'h0,       1, 0, "sw_oob");
    do_req(0, 0, 32'h0,   2'b11, 0, 32'h0,        32'hCAFEF00D, 0, 0, "lw_0_unchanged");
    do_req(0, 0, 32'hFFFFFFFC, 2'b11, 0, 32'h0,   32'h0,        1, 0, "lw_wrap");
    do_req(0, 1, 32'h10,  2'b00, 0, 32'hFFFFFFFF, 32'h0,        0, 0, "store_len0");
    do_req(0, 0, 32'h10,  2'b11, 0, 32'h0,        32'h123455EF, 0, 0, "lw_after_len0");
    do_req(0, 0, 32'h10,  2'b00, 0, 32'h0,        32'h0,        1, 0, "load_len0");
    do_req(0, 0, 32'h10,  2'b11, 0, 32'h0,        32'h123455EF, 0, 5, "lw_hold");
    do_req(0, 0, 32'h10,  2'b01, 1, 32'h0,        32'hFFFFFFEF, 0, 0, "lb_10");
    do_req(0, 1, 32'hFFC, 2'b11, 0, 32'h80000001, 32'h0,        0, 0, "sw_last");
    do_req(0, 0, 32'hFFE, 2'b10, 1, 32'h0,        32'hFFFF8000, 0, 0, "lh_last");

    // LATENCY=3 instance: reset while a store is in flight.
    do_req(1, 1, 32'h20, 2'b11, 0, 32'h11223344, 32'h0,        0, 0, "l3_sw_20");
    do_req(1, 0, 32'h20, 2'b11, 0, 32'h0,        32'h11223344, 0, 0, "l3_lw_20");
    @(negedge clk);
    sel = 1'b1;
    req_write = 1'b1; req_addr = 32'h20; req_len = 2'b11; req_signed = 1'b0;
    req_wdata = 32'hAABBCCDD; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    chk("l3_busy_ready", {31'b0, rdy3}, 32'd0);
    @(posedge clk);
    #2 rst3_n = 1'b0;
    #1;
    chk("l3_rst_ready", {31'b0, rdy3}, 32'd1);
    chk("l3_rst_valid", {31'b0, val3}, 32'd0);
    chk("l3_rst_rdata", rd3, 32'h0);
    chk("l3_rst_error", {31'b0, err3}, 32'd0);
    $display("txn l3_abort_store addr=00000020 ready=%0d valid=%0d rdata=%h", rdy3, val3, rd3);
    @(negedge clk);
    rst3_n = 1'b1;
    do_req(1, 0, 32'h20, 2'b11, 0, 32'h0, 32'h11223344, 0, 0, "l3_lw_after_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
